// File: rtl/fir_coeff_loader.sv
// Streams FIR coefficients through a small FIFO into the filter coefficient RAM.
// Define FIR_COEFF_LOADER_TIMEOUT_EN to abort loads that stall for 255 cycles.
`timescale 1ns/1ps

module fir_coeff_loader #(
  parameter int MAX_COEFF  = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        iClk12M,
  input  logic        iRsn,
  input  logic        iEnSample600k,
  input  logic        iStart,
  input  logic [5:0]  iNumOfCoeff,
  input  logic        iCoeffValid,
  input  logic [15:0] iCoeffData,
  output logic        oCoeffReady,
  output logic        oCoeffUpdateFlag,
  output logic [5:0]  oAddrRam,
  output logic [15:0] oWrDtRam,
  output logic        oWrEn,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [6:0]    MAX_C   = 7'(MAX_COEFF);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [5:0]  n_q, n_d;
  logic [5:0]  acc_q, acc_d;
  logic [5:0]  wr_q, wr_d;
  logic        err_q, err_d;

  logic        wen_q;
  logic [5:0]  addr_q;
  logic [15:0] data_q;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;

  logic fifo_full;
  logic fifo_empty;
  logic in_xfer;
  logic push;
  logic pop;
  logic flush;
  logic start_ok;
  logic tmo;

  assign fifo_full  = (cnt_q == DEPTH_C);
  assign fifo_empty = (cnt_q == '0);
  assign in_xfer    = (state_q == LOAD) ||
                      (state_q == DRAIN);

  assign oCoeffReady = (state_q == LOAD) &&
                       !fifo_full &&
                       (acc_q < n_q);

  assign push = iCoeffValid && oCoeffReady;

  // Sample strobe cycles belong to the filter's RAM read.
  assign pop = in_xfer &&
               !fifo_empty &&
               !iEnSample600k;

  assign start_ok = (iNumOfCoeff != 6'd0) &&
                    ({1'b0, iNumOfCoeff} <= MAX_C);

`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
  logic [7:0] idle_q, idle_d;

  always_comb begin
    idle_d = 8'd0;
    if ((state_q == LOAD) && fifo_empty &&
        !iCoeffValid) begin
      idle_d = idle_q + 8'd1;
    end
  end

  assign tmo = (idle_d == 8'hFF);

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      idle_q <= 8'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    if (push) begin
      acc_d = acc_q + 6'd1;
    end
    if (pop) begin
      wr_d = wr_q + 6'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          if (start_ok) begin
            n_d     = iNumOfCoeff;
            acc_d   = 6'd0;
            wr_d    = 6'd0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (tmo) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (acc_d == n_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_d == n_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign flush = (state_d == IDLE) &&
                 (state_q != IDLE);

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= IDLE;
      n_q     <= 6'd0;
      acc_q   <= 6'd0;
      wr_q    <= 6'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 16'd0;
      end
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= iCoeffData;
        wp_q        <= wp_q + PTR_ONE;
      end
      if (pop) begin
        rp_q <= rp_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      wen_q  <= 1'b0;
      addr_q <= 6'd0;
      data_q <= 16'd0;
    end else begin
      wen_q <= pop;
      if (pop) begin
        addr_q <= wr_q;
        data_q <= mem_q[rp_q];
      end
    end
  end

  assign oCoeffUpdateFlag = in_xfer;
  assign oBusy            = (state_q != IDLE);
  assign oDone            = (state_q == DONE);
  assign oErr             = err_q;
  assign oWrEn            = wen_q;
  assign oAddrRam         = addr_q;
  assign oWrDtRam         = data_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: random loads, strobes, backpressure,
// illegal counts, reset mid-load and the optional stall timeout.
`timescale 1ns/1ps

module tb_fir_coeff_loader;

  localparam int MAXC  = 40;
  localparam int DEPTH = 4;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        strobe = 1'b0;
  logic        start  = 1'b0;
  logic [5:0]  num    = 6'd0;
  logic        cv     = 1'b0;
  logic [15:0] cd     = 16'd0;

  logic        oCoeffReady;
  logic        oCoeffUpdateFlag;
  logic [5:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic        oWrEn;
  logic        oBusy;
  logic        oDone;
  logic        oErr;

  always #5 clk = ~clk;

  fir_coeff_loader #(
    .MAX_COEFF (MAXC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .iClk12M         (clk),
    .iRsn            (rst_n),
    .iEnSample600k   (strobe),
    .iStart          (start),
    .iNumOfCoeff     (num),
    .iCoeffValid     (cv),
    .iCoeffData      (cd),
    .oCoeffReady     (oCoeffReady),
    .oCoeffUpdateFlag(oCoeffUpdateFlag),
    .oAddrRam        (oAddrRam),
    .oWrDtRam        (oWrDtRam),
    .oWrEn           (oWrEn),
    .oBusy           (oBusy),
    .oDone           (oDone),
    .oErr            (oErr)
  );

  typedef struct packed {
    logic [5:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;

  int checks   = 0;
  int errors   = 0;
  int done_exp = 0;
  int err_exp  = 0;
  int wr_seen  = 0;
  int acc      = 0;
  int cyc      = 0;
  int smode    = 0;
  bit force_hi = 1'b0;
  bit prev_strobe = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    case (smode)
      1:       strobe = (cyc % 20 == 0);
      2:       strobe = ($urandom_range(3) == 0);
      3:       strobe = force_hi;
      default: strobe = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (oCoeffUpdateFlag !== (oBusy && !oDone)) begin
        errors++;
        $display("FAIL update_flag: got %b want %b", oCoeffUpdateFlag, oBusy && !oDone);
      end
      if (oWrEn) begin
        checks++;
        if (prev_strobe) begin
          errors++;
          $display("FAIL write_on_strobe: got oWrEn=1 want 0 addr=%0d", oAddrRam);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%h want none", oAddrRam, oWrDtRam);
        end else begin
          e = exp_q.pop_front();
          wr_seen++;
          if (oAddrRam !== e.a || oWrDtRam !== e.d) begin
            errors++;
            $display("FAIL ram_write: got addr=%0d data=%h want addr=%0d data=%h",
                     oAddrRam, oWrDtRam, e.a, e.d);
          end
        end
      end
      if (oDone) begin
        checks++;
        if (done_exp == 0 || exp_q.size() != 0) begin
          errors++;
          $display("FAIL done_pulse: got done with %0d writes pending, want %0d expected dones",
                   exp_q.size(), done_exp);
        end else begin
          done_exp--;
        end
      end
      if (oErr) begin
        checks++;
        if (err_exp == 0) begin
          errors++;
          $display("FAIL err_pulse: got oErr=1 want 0");
        end else begin
          err_exp--;
        end
      end
    end
    prev_strobe = strobe;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num   = 6'(n);
    if (n >= 1 && n <= MAXC) begin
      done_exp++;
      acc     = 0;
      wr_seen = 0;
    end else begin
      err_exp++;
    end
    tick();
    start = 1'b0;
    num   = 6'd0;
  endtask

  task automatic feed(input int n, input bit rnd_data, input bit rnd_valid,
                      input int stop_wr, input int inject);
    int budget = 3000;
    int it = 0;
    logic [15:0] d;
    d = rnd_data ? 16'($urandom) : 16'(acc + 1);
    while (acc < n && budget > 0 && !(stop_wr > 0 && wr_seen >= stop_wr)) begin
      cv = rnd_valid ? ($urandom_range(3) != 0) : 1'b1;
      cd = d;
      start = (it == inject);
      @(negedge clk);
      if (cv && oCoeffReady) begin
        exp_q.push_back({6'(acc), cd});
        acc++;
        d = rnd_data ? 16'($urandom) : 16'(acc + 1);
      end
      tick();
      budget--;
      it++;
    end
    cv    = 1'b0;
    start = 1'b0;
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: got %0d accepts want %0d", acc, n);
    end
  endtask

  task automatic wait_idle(input string name);
    int b = 2000;
    while ((done_exp > 0 || err_exp > 0) && b > 0) begin
      @(negedge clk);
      b--;
    end
    checks++;
    if (b == 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_complete: got done_exp=%0d err_exp=%0d pending=%0d want all 0",
               name, done_exp, err_exp, exp_q.size());
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int c;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({oCoeffReady, oCoeffUpdateFlag, oWrEn, oBusy, oDone, oErr, oAddrRam, oWrDtRam} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero want all 0");
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_start(40);
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL first_start: got busy=%b want 1", oBusy);
    end
    feed(40, 1'b0, 1'b0, 0, -1);
    wait_idle("nominal");

    smode = 1;
    do_start(8);
    feed(8, 1'b1, 1'b0, 0, -1);
    wait_idle("strobe");

    smode = 3;
    force_hi = 1'b1;
    tick();
    tick();
    do_start(10);
    for (int i = 0; i < 6; i++) begin
      cv = 1'b1;
      cd = 16'($urandom);
      @(negedge clk);
      if (cv && oCoeffReady) begin
        exp_q.push_back({6'(acc), cd});
        acc++;
      end
      tick();
    end
    cv = 1'b0;
    @(negedge clk);
    checks++;
    if (acc != DEPTH || oCoeffReady !== 1'b0) begin
      errors++;
      $display("FAIL backpressure: got accepts=%0d ready=%b want %0d and 0",
               acc, oCoeffReady, DEPTH);
    end
    tick();
    force_hi = 1'b0;
    feed(10, 1'b1, 1'b0, 0, -1);
    wait_idle("backpressure");
    smode = 0;

    do_start(0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (oBusy !== 1'b0) begin
        errors++;
        $display("FAIL illegal_zero_busy: got %b want 0", oBusy);
      end
    end
    tick();
    do_start(41);
    wait_idle("illegal");
    checks++;
    if (oBusy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_41_busy: got %b want 0", oBusy);
    end

    for (int k = 0; k < 6; k++) begin
      smode = 2;
      n = $urandom_range(MAXC, 1);
      do_start(n);
      feed(n, 1'b1, 1'b1, 0, (k % 2 == 0) ? 3 : -1);
      wait_idle("random");
    end
    smode = 0;

    do_start(20);
    feed(20, 1'b1, 1'b0, 5, -1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({oCoeffReady, oCoeffUpdateFlag, oWrEn, oBusy, oDone, oErr, oAddrRam, oWrDtRam} !== '0) begin
      errors++;
      $display("FAIL reset_midload: got nonzero outputs want all 0");
    end
    exp_q.delete();
    done_exp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(3);
    feed(3, 1'b1, 1'b0, 0, -1);
    wait_idle("after_reset");

    do_start(5);
    feed(2, 1'b1, 1'b0, 0, -1);
`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
    done_exp--;
    err_exp++;
    c = 0;
    while (err_exp > 0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c < 240 || c > 270) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles want about 256", c);
    end
    @(negedge clk);
    checks++;
    if (oCoeffUpdateFlag !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: got flag=%b busy=%b want 0 0", oCoeffUpdateFlag, oBusy);
    end
`else
    c = 0;
    repeat (300) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (oBusy !== 1'b1 || oCoeffUpdateFlag !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout: got busy=%b flag=%b after %0d cycles want 1 1",
               oBusy, oCoeffUpdateFlag, c);
    end
    #2;
    rst_n = 1'b0;
    done_exp = 0;
    #20;
    rst_n = 1'b1;
`endif

    tick();
    checks++;
    if (exp_q.size() != 0 || err_exp != 0) begin
      errors++;
      $display("FAIL leftovers: got pending=%0d err_exp=%0d want 0 0", exp_q.size(), err_exp);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
